// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run-control sequencer: state codes,
// return-value width and the default watchdog budget.
package run_ctrl_pkg;

    localparam int          RET_W           = 16;
    localparam int unsigned DEF_CYCLE_LIMIT = 50000;

    // state     | meaning
    // ----------+-----------------------------------------------
    // ST_IDLE   | after reset, CPU gated, waiting for start/step
    // ST_RUN    | CPU free running
    // ST_PAUSED | stopped by command or after a single step
    // ST_STEP   | exactly one enabled cycle, then PAUSED
    // ST_HALTED | CPU reported halt, result latched (sticky)
    // ST_TIMEOUT| cycle budget exhausted (sticky)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_PAUSED  = 3'd2;
    localparam logic [2:0] ST_STEP    = 3'd3;
    localparam logic [2:0] ST_HALTED  = 3'd4;
    localparam logic [2:0] ST_TIMEOUT = 3'd5;

endpackage

// File: rtl/run_ctrl.sv
// Run-control sequencer: gates the CPU clock-enable from start/stop/step
// commands, counts enabled cycles, latches the return value on halt and
// stops the CPU when the cycle budget is exhausted.
// Optional macro RUN_CTRL_SIM_FINISH_EN: print a message and end the
// simulation on entry to HALTED or TIMEOUT (simulation-only code).
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned CYCLE_LIMIT = DEF_CYCLE_LIMIT,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             halt_in,
    input  logic [RET_W-1:0] ret_val,
    output logic             cpu_en,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic [RET_W-1:0] result,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       state
);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cycle_count;
    logic [RET_W-1:0] r_result;
    logic             w_en;
    logic             w_at_limit;
    logic             w_halt;

    assign w_en       = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_halt     = w_en && halt_in;
    // The last permitted enabled cycle is the one entered with count LIMIT-1.
    assign w_at_limit = (r_cycle_count == CNT_W'(CYCLE_LIMIT - 1));

    // Next-state decode; halt beats timeout beats stop/step completion.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_PAUSED: begin
                if (start)
                    w_state_nxt = ST_RUN;
                else if (step)
                    w_state_nxt = ST_STEP;
            end
            ST_RUN, ST_STEP: begin
                if (halt_in)
                    w_state_nxt = ST_HALTED;
                else if (w_at_limit)
                    w_state_nxt = ST_TIMEOUT;
                else if (r_state == ST_STEP)
                    w_state_nxt = ST_PAUSED;
                else if (stop)
                    w_state_nxt = ST_PAUSED;
            end
            ST_HALTED, ST_TIMEOUT: w_state_nxt = r_state;
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    // State, cycle counter and halt result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cycle_count <= '0;
            r_result      <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Cannot wrap: TIMEOUT is forced once the count reaches the limit.
            if (w_en)
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            if (w_halt)
                r_result <= ret_val;
        end
    end

`ifdef RUN_CTRL_SIM_FINISH_EN
    // End the simulation on the edge that enters HALTED or TIMEOUT.
    always @(posedge clk) begin
        if (!rst && w_en) begin
            if (halt_in) begin
                $display("Finished with << %0d >>", ret_val);
                $finish;
            end else if (w_at_limit) begin
                $display("ran for %0d cycles", CYCLE_LIMIT);
                $finish;
            end
        end
    end
`else
    // Halt and timeout are reported only through done / timed_out.
`endif

    assign cpu_en      = w_en;
    assign busy        = w_en;
    assign done        = (r_state == ST_HALTED);
    assign timed_out   = (r_state == ST_TIMEOUT);
    assign result      = r_result;
    assign cycle_count = r_cycle_count;
    assign state       = r_state;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: three instances with different cycle
// budgets (default, 8, 4), each driven by its own signal set.
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        rst     [3];
    logic        start   [3];
    logic        stop    [3];
    logic        step    [3];
    logic        halt_in [3];
    logic [15:0] ret_val [3];
    logic        cpu_en      [3];
    logic        busy        [3];
    logic        done        [3];
    logic        timed_out   [3];
    logic [15:0] result      [3];
    logic [31:0] cycle_count [3];
    logic [2:0]  state       [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    run_ctrl #(.CYCLE_LIMIT(50000), .CNT_W(32)) u_dut0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .stop(stop[0]), .step(step[0]),
        .halt_in(halt_in[0]), .ret_val(ret_val[0]), .cpu_en(cpu_en[0]), .busy(busy[0]),
        .done(done[0]), .timed_out(timed_out[0]), .result(result[0]),
        .cycle_count(cycle_count[0]), .state(state[0]));

    run_ctrl #(.CYCLE_LIMIT(8), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .stop(stop[1]), .step(step[1]),
        .halt_in(halt_in[1]), .ret_val(ret_val[1]), .cpu_en(cpu_en[1]), .busy(busy[1]),
        .done(done[1]), .timed_out(timed_out[1]), .result(result[1]),
        .cycle_count(cycle_count[1]), .state(state[1]));

    run_ctrl #(.CYCLE_LIMIT(4), .CNT_W(32)) u_dut2 (
        .clk(clk), .rst(rst[2]), .start(start[2]), .stop(stop[2]), .step(step[2]),
        .halt_in(halt_in[2]), .ret_val(ret_val[2]), .cpu_en(cpu_en[2]), .busy(busy[2]),
        .done(done[2]), .timed_out(timed_out[2]), .result(result[2]),
        .cycle_count(cycle_count[2]), .state(state[2]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs read there too.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        tick(1);
        rst[d] = 1'b0;
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        tick(1);
        start[d] = 1'b0;
    endtask

    task automatic pulse_step(input int d);
        step[d] = 1'b1;
        tick(1);
        step[d] = 1'b0;
    endtask

    task automatic pulse_stop(input int d);
        stop[d] = 1'b1;
        tick(1);
        stop[d] = 1'b0;
    endtask

    task automatic halt_with(input int d, input logic [15:0] v);
        halt_in[d] = 1'b1;
        ret_val[d] = v;
        tick(1);
        halt_in[d] = 1'b0;
        ret_val[d] = 16'h0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; start[d] = 1'b0; stop[d] = 1'b0; step[d] = 1'b0;
            halt_in[d] = 1'b0; ret_val[d] = 16'h0;
        end
        tick(1);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // Reset values.
        check_val("rst_state", state[0], 0);
        check_val("rst_count", cycle_count[0], 0);
        check_val("rst_result", result[0], 0);
        check_val("rst_cpu_en", cpu_en[0], 0);
        check_val("rst_flags", {busy[0], done[0], timed_out[0]}, 0);

        // stop in IDLE is ignored.
        pulse_stop(0);
        check_val("idle_stop_ignored", state[0], 0);

        // Run, halt in the 5th enabled cycle with 0x2A.
        pulse_start(0);
        check_val("run_cpu_en", cpu_en[0], 1);
        check_val("run_busy", busy[0], 1);
        check_val("run_state", state[0], 1);
        tick(4);
        check_val("run_count4", cycle_count[0], 4);
        halt_with(0, 16'h002A);
        check_val("halt_done", done[0], 1);
        check_val("halt_state", state[0], 4);
        check_val("halt_result", result[0], 42);
        check_val("halt_count", cycle_count[0], 5);
        check_val("halt_cpu_en", cpu_en[0], 0);
        pulse_start(0);
        pulse_step(0);
        tick(2);
        check_val("halt_sticky", state[0], 4);
        check_val("halt_count_hold", cycle_count[0], 5);

        // Reset from HALTED clears result; then stop after 3 cycles, two steps.
        do_reset(0);
        check_val("rst2_result", result[0], 0);
        check_val("rst2_state", state[0], 0);
        pulse_start(0);
        tick(2);
        pulse_stop(0);
        check_val("stop_state", state[0], 2);
        check_val("stop_count", cycle_count[0], 3);
        halt_with(0, 16'h1234);
        check_val("paused_halt_ignored", state[0], 2);
        check_val("paused_result_hold", result[0], 0);
        pulse_step(0);
        check_val("step1_state", state[0], 3);
        check_val("step1_cpu_en", cpu_en[0], 1);
        tick(1);
        check_val("step1_done", state[0], 2);
        check_val("step1_count", cycle_count[0], 4);
        pulse_step(0);
        tick(1);
        check_val("step2_state", state[0], 2);
        check_val("step2_count", cycle_count[0], 5);
        pulse_start(0);
        check_val("resume_state", state[0], 1);

        // Mid-run reset at count 10.
        tick(5);
        check_val("midrun_count", cycle_count[0], 10);
        do_reset(0);
        check_val("midrun_rst_state", state[0], 0);
        check_val("midrun_rst_count", cycle_count[0], 0);
        check_val("midrun_rst_result", result[0], 0);
        check_val("midrun_rst_cpu_en", cpu_en[0], 0);

        // start and step together from IDLE: start wins.
        start[0] = 1'b1;
        step[0]  = 1'b1;
        tick(1);
        start[0] = 1'b0;
        step[0]  = 1'b0;
        check_val("start_step_prio", state[0], 1);
        tick(2);
        check_val("start_step_run", state[0], 1);

        // CYCLE_LIMIT=8 timeout.
        pulse_start(1);
        tick(7);
        check_val("to_before_state", state[1], 1);
        check_val("to_before_count", cycle_count[1], 7);
        tick(1);
        check_val("to_flag", timed_out[1], 1);
        check_val("to_state", state[1], 5);
        check_val("to_count", cycle_count[1], 8);
        check_val("to_cpu_en", cpu_en[1], 0);
        pulse_start(1);
        pulse_step(1);
        tick(1);
        check_val("to_sticky", state[1], 5);
        check_val("to_count_hold", cycle_count[1], 8);

        // CYCLE_LIMIT=4: step from IDLE, then halt on the last budget cycle.
        pulse_step(2);
        check_val("idle_step_state", state[2], 3);
        tick(1);
        check_val("idle_step_paused", state[2], 2);
        check_val("idle_step_count", cycle_count[2], 1);
        do_reset(2);
        pulse_start(2);
        tick(3);
        check_val("lim4_count3", cycle_count[2], 3);
        halt_with(2, 16'd7);
        check_val("lim4_state", state[2], 4);
        check_val("lim4_timed_out", timed_out[2], 0);
        check_val("lim4_result", result[2], 7);
        check_val("lim4_count", cycle_count[2], 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
Run-control sequencer for the pipeline CPU. It gates the CPU clock-enable and accepts start/stop/single-step commands from the debug/testbench side. It counts enabled cycles, detects the CPU halt flag, enforces a cycle-budget watchdog, and latches the CPU return value. It sits between the debug interface and the CPU top level and replaces the free-running cycle monitor with a synthesizable controller.

Parameters:
CYCLE_LIMIT, 50000, enabled cycles allowed before the watchdog timeout fires (must be >= 1)
CNT_W, 32, width of the cycle counter (must satisfy CYCLE_LIMIT < 2^CNT_W)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
start  in  1  pulse; begin or resume free running
stop  in  1  pulse; pause a running CPU
step  in  1  pulse; run exactly one enabled cycle
halt_in  in  1  CPU halt indication (isHalt)
ret_val  in  16  CPU return value, valid when halt_in=1
cpu_en  out  1  CPU clock-enable
busy  out  1  1 in RUN or STEP
done  out  1  1 in HALTED
timed_out  out  1  1 in TIMEOUT
result  out  16  ret_val latched at halt
cycle_count  out  CNT_W  number of enabled cycles so far
state  out  3  encoded FSM state (debug)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, cycle_count=0, result=0. All flags and cpu_en are 0 in the next cycle. rst has priority over everything, including mid-RUN.
- State encoding: IDLE=0, RUN=1, PAUSED=2, STEP=3, HALTED=4, TIMEOUT=5. Codes 6 and 7 are illegal and go to IDLE on the next clock.
- Moore outputs decoded from the state register:
  - cpu_en = busy = (RUN or STEP)
  - done = HALTED
  - timed_out = TIMEOUT
- Counter: cycle_count increments by 1 on every posedge where cpu_en=1, including the cycle that causes a halt or timeout. It never wraps and holds in all other states.
- halt_in is sampled only when cpu_en=1. Otherwise it is ignored.
- Transitions, evaluated in priority order while cpu_en=1 (RUN or STEP):
  1. halt_in=1 -> HALTED; result <= ret_val.
  2. cycle_count == CYCLE_LIMIT-1 -> TIMEOUT. cycle_count ends at CYCLE_LIMIT. A halt in the same cycle wins.
  3. From RUN: stop=1 -> PAUSED.
  4. From STEP: -> PAUSED unconditionally. This gives exactly one enabled cycle.
  5. Otherwise stay in the current state.
- IDLE:
  - start -> RUN
  - step -> STEP
  - stop is ignored
  - If start and step are both asserted, start wins.
- PAUSED:
  - start -> RUN
  - step -> STEP
  - stop is ignored
  - If start and step are both asserted, start wins.
- HALTED and TIMEOUT are sticky. All commands are ignored; only rst leaves these states.
- Latency: a command sampled at edge N makes cpu_en=1 in cycle N+1. The halt edge makes cpu_en=0 and done=1 in the next cycle. The CPU therefore sees no further enabled cycles after its halt cycle.
- result changes only on a halt transition or on reset.

Optional Feature:
RUN_CTRL_SIM_FINISH_EN
- Defined: on the clock edge entering HALTED, the block prints "Finished with << %0d >>" using ret_val, then calls $finish. On entry to TIMEOUT, it prints "ran for <CYCLE_LIMIT> cycles", then calls $finish. This code is simulation-only and is excluded from synthesis.
- Undefined: no system tasks are present, and the block is fully synthesizable. The flags remain the only indication of halt or timeout.

Decomposition:
- Shared package run_ctrl_pkg holds:
  - the state localparams/typedef (IDLE..TIMEOUT, 3-bit)
  - RET_W=16
  - the default CYCLE_LIMIT constant
- No sub-module; the FSM and counter stay in a single module.

Test Plan:
- rst, then start; halt_in=1 with ret_val=16'h002A in the 5th enabled cycle -> done=1 next cycle, result=42, cycle_count=5, cpu_en=0 thereafter.
- CYCLE_LIMIT=8, start, halt_in held 0 -> timed_out=1 after 8 enabled cycles, cycle_count=8. Later start/step pulses leave the state at TIMEOUT.
- start, stop after 3 cycles -> PAUSED, cycle_count=3. Then step x2 -> one enabled cycle each, cycle_count=5, state=PAUSED. Then start -> RUN.
- CYCLE_LIMIT=4 with halt_in=1 in the 4th enabled cycle (ret_val=7) -> HALTED, not TIMEOUT; result=7, cycle_count=4.
- rst asserted mid-RUN at cycle_count=10 -> next cycle state=IDLE, cycle_count=0, result=0, cpu_en=0. start and step in the same cycle from IDLE -> RUN.
- Build with RUN_CTRL_SIM_FINISH_EN defined and a halt with ret_val=3 -> the "Finished with << 3 >>" message prints and the simulation terminates.
